al_npc_commit_reader: RTL

AL_NPC_COMMIT_READER -- requirements
Module: al_npc_commit_reader

---
 rtl/al_npc_commit_reader_pkg.sv | 36 +++
 rtl/al_npc_commit_reader_if.sv | 25 ++
 rtl/al_npc_head_ctr.sv | 45 ++++
 rtl/al_npc_commit_reader.sv | 131 +++++++++++++
 4 files changed

// File: rtl/al_npc_commit_reader_pkg.sv
// Shared types for the active-list NPC commit reader: FSM state enum and the
// active-depth helper. Default sizing macros are supplied here when not predefined.
`ifndef SIZE_ACTIVELIST
`define SIZE_ACTIVELIST 64
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 6
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef NUM_PARTS_AL
`define NUM_PARTS_AL 4
`endif

package al_npc_commit_reader_pkg;

    typedef enum logic [1:0] {
        WAIT_RDY = 2'd0,
        RUN      = 2'd1,
        RECONF   = 2'd2
    } al_npc_state_e;

    // Entries reachable with the given partition mask: popcount(mask) * entries-per-partition.
    function automatic logic [31:0] active_depth(input logic [31:0] part_mask,
                                                 input logic [31:0] depth,
                                                 input logic [31:0] num_parts);
        logic [31:0] ones;
        ones = 32'd0;
        for (int i = 0; i < 32; i++) begin
            ones = ones + {31'd0, part_mask[i]};
        end
        return ones * (depth / num_parts);
    endfunction

endpackage

// File: rtl/al_npc_commit_reader_if.sv
// Commit/RAM/NPC handshake bundle of the active-list NPC commit reader.
// Member names are seen from the reader side (master); slave is the environment.
interface al_npc_commit_reader_if #(
    parameter int INDEX = `SIZE_ACTIVELIST_LOG,
    parameter int WIDTH = `SIZE_PC
) ();
    logic             commitReq_i;
    logic             commitReady_o;
    logic [INDEX-1:0] ramAddr_o;
    logic [WIDTH-1:0] ramData_i;
    logic             npcValid_o;
    logic             npcReady_i;
    logic [WIDTH-1:0] npc_o;
    logic [INDEX-1:0] npcIdx_o;

    modport master (
        input  commitReq_i, ramData_i, npcReady_i,
        output commitReady_o, ramAddr_o, npcValid_o, npc_o, npcIdx_o
    );

    modport slave (
        output commitReq_i, ramData_i, npcReady_i,
        input  commitReady_o, ramAddr_o, npcValid_o, npc_o, npcIdx_o
    );
endinterface

// File: rtl/al_npc_head_ctr.sv
// Active-list read head pointer: advances on accept, wraps at the end of the
// currently active partitions, cleared by flush or reconfiguration.
module al_npc_head_ctr
    import al_npc_commit_reader_pkg::*;
#(
    parameter int DEPTH     = `SIZE_ACTIVELIST,
    parameter int INDEX     = `SIZE_ACTIVELIST_LOG,
    parameter int NUM_PARTS = `NUM_PARTS_AL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 advance,
    input  logic                 clear,
    input  logic [NUM_PARTS-1:0] part_mask,
    output logic [INDEX-1:0]     head
);
    logic [INDEX-1:0] head_r;
    logic [31:0]      depth_s;
    logic [31:0]      next_s;
    logic             wrap_s;

    // Wrap also covers a head left beyond a freshly shrunk depth.
    always_comb begin
        depth_s = active_depth(32'(part_mask), 32'(DEPTH), 32'(NUM_PARTS));
        next_s  = 32'(head_r) + 32'd1;
        wrap_s  = (next_s >= depth_s);
    end

    // Head pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r <= {INDEX{1'b0}};
        end else if (clear) begin
            head_r <= {INDEX{1'b0}};
        end else if (advance && wrap_s) begin
            head_r <= {INDEX{1'b0}};
        end else if (advance) begin
            head_r <= head_r + INDEX'(1'b1);
        end else begin
            head_r <= head_r;
        end
    end

    assign head = head_r;
endmodule

// File: rtl/al_npc_commit_reader.sv
// Active-list NPC commit reader: reads the head entry's next-PC from the
// partitioned NPC RAM and presents it registered. Optional stall counter: ALNPC_RD_STALL_CNT_EN.
module al_npc_commit_reader
    import al_npc_commit_reader_pkg::*;
#(
    parameter int DEPTH     = `SIZE_ACTIVELIST,
    parameter int INDEX     = `SIZE_ACTIVELIST_LOG,
    parameter int WIDTH     = `SIZE_PC,
    parameter int NUM_PARTS = `NUM_PARTS_AL
) (
    input  logic                    clk,
    input  logic                    reset,
    al_npc_commit_reader_if.master  bus,
    input  logic [NUM_PARTS-1:0]    alPartitionActive_i,
    input  logic                    alNPcReady_i,
    input  logic                    flush_i,
    output logic [INDEX-1:0]        headPtr_o
`ifdef ALNPC_RD_STALL_CNT_EN
    ,
    output logic [31:0]             stallCnt_o
`endif
);
    al_npc_state_e        state_r;
    logic [NUM_PARTS-1:0] mask_r;
    logic                 npc_valid_r;
    logic [WIDTH-1:0]     npc_r;
    logic [INDEX-1:0]     npc_idx_r;
    logic [INDEX-1:0]     head_s;
    logic                 mask_any_s;
    logic                 commit_ready_s;
    logic                 accept_s;
    logic                 head_clear_s;

    // Handshake decode; an all-zero mask never accepts since it has no depth.
    always_comb begin
        mask_any_s     = |alPartitionActive_i;
        commit_ready_s = (state_r == RUN) & mask_any_s & (~npc_valid_r | bus.npcReady_i);
        accept_s       = bus.commitReq_i & commit_ready_s & ~flush_i;
        head_clear_s   = flush_i | ((state_r == RECONF) & ~npc_valid_r);
    end

    al_npc_head_ctr #(
        .DEPTH     (DEPTH),
        .INDEX     (INDEX),
        .NUM_PARTS (NUM_PARTS)
    ) u_head_ctr (
        .clk       (clk),
        .reset     (reset),
        .advance   (accept_s),
        .clear     (head_clear_s),
        .part_mask (alPartitionActive_i),
        .head      (head_s)
    );

    // Control FSM with the registered NPC output stage and partition-mask history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= WAIT_RDY;
            mask_r      <= {NUM_PARTS{1'b0}};
            npc_valid_r <= 1'b0;
            npc_r       <= {WIDTH{1'b0}};
            npc_idx_r   <= {INDEX{1'b0}};
        end else begin
            mask_r <= alPartitionActive_i;

            if (flush_i) begin
                npc_valid_r <= 1'b0;
            end else if (accept_s) begin
                npc_valid_r <= 1'b1;
                npc_r       <= bus.ramData_i;
                npc_idx_r   <= head_s;
            end else if (bus.npcReady_i) begin
                npc_valid_r <= 1'b0;
            end else begin
                npc_valid_r <= npc_valid_r;
            end

            // Flush freezes the state except that it completes a pending reconfiguration.
            case (state_r)
                WAIT_RDY: begin
                    if (!flush_i && alNPcReady_i && mask_any_s) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= WAIT_RDY;
                    end
                end
                RUN: begin
                    if (!flush_i && ((alPartitionActive_i != mask_r) || !mask_any_s)) begin
                        state_r <= RECONF;
                    end else begin
                        state_r <= RUN;
                    end
                end
                RECONF: begin
                    if (flush_i || !npc_valid_r) begin
                        state_r <= WAIT_RDY;
                    end else begin
                        state_r <= RECONF;
                    end
                end
                default: begin
                    state_r <= WAIT_RDY;
                end
            endcase
        end
    end

`ifdef ALNPC_RD_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles a commit request was refused.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'd0;
        end else if (bus.commitReq_i && !commit_ready_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stallCnt_o = stall_cnt_r;
`endif

    assign bus.commitReady_o = commit_ready_s;
    assign bus.ramAddr_o     = head_s;
    assign bus.npcValid_o    = npc_valid_r;
    assign bus.npc_o         = npc_r;
    assign bus.npcIdx_o      = npc_idx_r;
    assign headPtr_o         = head_s;
endmodule
